// File: rtl/framebuffer_fill_engine_if.sv
// Command handshake plus Avalon-MM write bus for the framebuffer fill engine.
// master: the engine (accepts commands, initiates writes); slave: command source and responder.
interface framebuffer_fill_engine_if #(
  parameter int unsigned AVN_AW = 19,
  parameter int unsigned AVN_DW = 16,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [XW-1:0]         cmd_x0;
  logic [XW-1:0]         cmd_x1;
  logic [YW-1:0]         cmd_y0;
  logic [YW-1:0]         cmd_y1;
  logic [AVN_DW-1:0]     cmd_color;

  logic                  avn_write;
  logic                  avn_read;
  logic [AVN_AW-1:0]     avn_address;
  logic [AVN_DW-1:0]     avn_writedata;
  logic [AVN_DW/8-1:0]   avn_byteenable;
  logic                  avn_waitrequest;

  modport master (
    input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    output cmd_ready,
    output avn_write, avn_read, avn_address, avn_writedata, avn_byteenable,
    input  avn_waitrequest
  );

  modport slave (
    output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
    input  cmd_ready,
    input  avn_write, avn_read, avn_address, avn_writedata, avn_byteenable,
    output avn_waitrequest
  );
endinterface

// File: rtl/framebuffer_fill_engine.sv
// Rectangle fill engine: one command at a time, row-major single-word Avalon writes.
// Optional FILL_CLIP_EN clamps the rectangle to the visible H_RES x V_RES area at accept.
module framebuffer_fill_engine #(
  parameter int unsigned AVN_AW = 19,
  parameter int unsigned AVN_DW = 16,
  parameter int unsigned H_RES  = 640,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  framebuffer_fill_engine_if.master bus,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

  localparam logic [AVN_AW-1:0] Pitch = AVN_AW'(H_RES);

  state_e state_q, state_d;

  logic [XW-1:0]     x0_q, x1_q, x_q;
  logic [YW-1:0]     y0_q, y1_q, y_q;
  logic [AVN_DW-1:0] color_q;
  logic [AVN_AW-1:0] row_base_q, addr_q;

  logic [XW-1:0]     x1_eff;
  logic [YW-1:0]     y1_eff;
  logic              cmd_empty;
  logic              accept, wr_accept, x_last, y_last;
  logic [AVN_AW-1:0] load_base, next_base;

  always_comb begin
`ifdef FILL_CLIP_EN
    localparam logic [XW-1:0] XMax = XW'(H_RES - 1);
    localparam logic [YW-1:0] YMax = YW'(V_RES - 1);
    localparam logic [XW:0]   XLim = (XW+1)'(H_RES);
    localparam logic [YW:0]   YLim = (YW+1)'(V_RES);
    x1_eff    = (bus.cmd_x1 > XMax) ? XMax : bus.cmd_x1;
    y1_eff    = (bus.cmd_y1 > YMax) ? YMax : bus.cmd_y1;
    cmd_empty = ({1'b0, bus.cmd_x0} >= XLim) || ({1'b0, bus.cmd_y0} >= YLim) ||
                (bus.cmd_x0 > x1_eff) || (bus.cmd_y0 > y1_eff);
`else
    x1_eff    = bus.cmd_x1;
    y1_eff    = bus.cmd_y1;
    cmd_empty = (bus.cmd_x0 > bus.cmd_x1) || (bus.cmd_y0 > bus.cmd_y1);
`endif
  end

  assign accept    = (state_q == StIdle) && bus.cmd_valid;
  assign wr_accept = (state_q == StWrite) && !bus.avn_waitrequest;
  assign x_last    = (x_q == x1_q);
  assign y_last    = (y_q == y1_q);
  assign load_base = AVN_AW'(y0_q) * Pitch;
  assign next_base = row_base_q + Pitch;

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.cmd_valid) state_d = cmd_empty ? StDone : StLoad;
      StLoad:  state_d = StWrite;
      StWrite: if (wr_accept && x_last && y_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.cmd_ready      = (state_q == StIdle);
    busy               = (state_q != StIdle);
    done               = (state_q == StDone);
    bus.avn_write      = (state_q == StWrite);
    bus.avn_read       = 1'b0;
    bus.avn_address    = addr_q;
    bus.avn_writedata  = color_q;
    bus.avn_byteenable = '1;
  end

  // Command latch and address walker; address only advances on an accepted write
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      if (accept) begin
        x0_q    <= bus.cmd_x0;
        x1_q    <= x1_eff;
        y0_q    <= bus.cmd_y0;
        y1_q    <= y1_eff;
        color_q <= bus.cmd_color;
      end
      if (state_q == StLoad) begin
        row_base_q <= load_base;
        addr_q     <= load_base + AVN_AW'(x0_q);
        x_q        <= x0_q;
        y_q        <= y0_q;
      end
      if (wr_accept) begin
        if (!x_last) begin
          x_q    <= x_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end else if (!y_last) begin
          y_q        <= y_q + 1'b1;
          x_q        <= x0_q;
          row_base_q <= next_base;
          addr_q     <= next_base + AVN_AW'(x0_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_fill_engine.sv
// Self-checking bench for framebuffer_fill_engine: directed table, reset corner, random fills.
module tb_framebuffer_fill_engine;

  localparam int AW   = 19;
  localparam int DW   = 16;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int HRES = 640;
  localparam int VRES = 480;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic busy, done;

  framebuffer_fill_engine_if #(.AVN_AW(AW), .AVN_DW(DW), .XW(XW), .YW(YW)) bus ();

  framebuffer_fill_engine #(
    .AVN_AW(AW), .AVN_DW(DW), .H_RES(HRES), .V_RES(VRES), .XW(XW), .YW(YW)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: the list of word addresses a fill must touch, in order.
  int exp_q[$];

  task automatic build_model(input int x0, input int x1, input int y0, input int y1);
    int xe, ye;
    xe = x1;
    ye = y1;
    exp_q.delete();
`ifdef FILL_CLIP_EN
    if (xe > HRES - 1) xe = HRES - 1;
    if (ye > VRES - 1) ye = VRES - 1;
    if (x0 >= HRES || y0 >= VRES) return;
`endif
    for (int y = y0; y <= ye; y++)
      for (int x = x0; x <= xe; x++)
        exp_q.push_back((y * HRES + x) % (1 << AW));
  endtask

  int r_count, r_first, r_done_cyc;

  task automatic drive_cmd(input int x0, input int x1, input int y0, input int y1,
                           input logic [15:0] color);
    bus.cmd_x0    = XW'(x0);
    bus.cmd_x1    = XW'(x1);
    bus.cmd_y0    = YW'(y0);
    bus.cmd_y1    = YW'(y1);
    bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
  endtask

  // stall_mode: 0 none, 1 three stall cycles on the first write, 2 random stalls
  task automatic run_cmd(input int x0, input int x1, input int y0, input int y1,
                         input logic [15:0] color, input int stall_mode, input bit hold_valid);
    int  n, stalls, popped, stall_first;
    bit  finished, wr;
    stalls      = 0;
    popped      = 0;
    stall_first = 0;
    finished    = 1'b0;
    r_first     = -1;
    r_done_cyc  = -1;
    build_model(x0, x1, y0, y1);
    n = exp_q.size();
    check("ready_before_cmd", {31'd0, bus.cmd_ready}, 1);
    drive_cmd(x0, x1, y0, y1, color);
    bus.avn_waitrequest = 1'b0;
    @(posedge sys_clk);
    for (int cyc = 1; cyc <= 2000 && !finished; cyc++) begin
      @(negedge sys_clk);
      if (!hold_valid) bus.cmd_valid = 1'b0;
      if (bus.avn_write) begin
        if (r_first < 0) r_first = int'(bus.avn_address);
        if (exp_q.size() == 0) begin
          check("extra_write", 1, 0);
        end else begin
          check("write_addr", 32'(bus.avn_address), exp_q[0]);
          check("write_data", 32'(bus.avn_writedata), 32'(color));
          check("write_be_rd", {29'd0, bus.avn_read, bus.avn_byteenable}, 32'b011);
        end
        if (stall_mode == 1)      wr = (popped == 0) && (stall_first < 3);
        else if (stall_mode == 2) wr = ($urandom_range(0, 2) == 0);
        else                      wr = 1'b0;
        if (wr) begin
          stalls++;
          if (popped == 0) stall_first++;
        end else begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          popped++;
        end
        bus.avn_waitrequest = wr;
      end else begin
        bus.avn_waitrequest = 1'b0;
      end
      if (done) begin
        r_done_cyc = cyc;
        check("done_cycle", cyc, (n == 0) ? 1 : n + 2 + stalls);
        check("write_count", popped, n);
        bus.cmd_valid = 1'b0;
        finished = 1'b1;
      end else begin
        check("busy_not_ready", {30'd0, busy, bus.cmd_ready}, 32'b10);
      end
    end
    r_count = popped;
    if (!finished) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge sys_clk);
      check("idle_after_done", {29'd0, busy, bus.cmd_ready, done}, 32'b010);
    end
  endtask

  typedef struct {
    int          x0, x1, y0, y1;
    logic [15:0] color;
    int          stall;
    bit          hold;
    int          first;
    int          count;
    int          done_cyc;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int popped;
    tbl[0] = '{1, 2, 1, 2, 16'hF800, 0, 1'b0, 641, 4, 6};
    tbl[1] = '{1, 2, 1, 2, 16'hF800, 1, 1'b0, 641, 4, 9};
    tbl[2] = '{5, 4, 0, 0, 16'h1234, 0, 1'b0, 0, 0, 1};
`ifdef FILL_CLIP_EN
    tbl[3] = '{638, 700, 479, 479, 16'h07E0, 0, 1'b0, 307198, 2, 4};
`else
    tbl[3] = '{638, 700, 479, 479, 16'h07E0, 0, 1'b0, 307198, 63, 65};
`endif
    tbl[4] = '{639, 639, 479, 479, 16'h001F, 0, 1'b1, 307199, 1, 3};

    sys_rst             = 1'b1;
    bus.cmd_valid       = 1'b0;
    bus.cmd_x0          = '0;
    bus.cmd_x1          = '0;
    bus.cmd_y0          = '0;
    bus.cmd_y1          = '0;
    bus.cmd_color       = '0;
    bus.avn_waitrequest = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_ctrl", {28'd0, bus.avn_write, done, busy, bus.cmd_ready}, 32'b0001);
    check("reset_addr", 32'(bus.avn_address), 0);
    check("reset_data", 32'(bus.avn_writedata), 0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 5; i++) begin
      run_cmd(tbl[i].x0, tbl[i].x1, tbl[i].y0, tbl[i].y1, tbl[i].color, tbl[i].stall,
              tbl[i].hold);
      check("tbl_count", r_count, tbl[i].count);
      check("tbl_done_cycle", r_done_cyc, tbl[i].done_cyc);
      if (tbl[i].count > 0) check("tbl_first_addr", r_first, tbl[i].first);
    end

    // Reset after five accepted writes of a 4x4 fill
    build_model(10, 13, 20, 23);
    drive_cmd(10, 13, 20, 23, 16'hABCD);
    bus.avn_waitrequest = 1'b0;
    popped = 0;
    @(posedge sys_clk);
    for (int cyc = 1; cyc <= 50; cyc++) begin
      @(negedge sys_clk);
      bus.cmd_valid = 1'b0;
      if (popped == 5) break;
      if (bus.avn_write) begin
        check("rst_seq_addr", 32'(bus.avn_address), exp_q[0]);
        void'(exp_q.pop_front());
        popped++;
      end
    end
    check("rst_seq_writes", popped, 5);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_op", {28'd0, bus.avn_write, done, busy, bus.cmd_ready}, 32'b0001);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_release", {28'd0, bus.avn_write, done, busy, bus.cmd_ready}, 32'b0001);
    run_cmd(3, 4, 2, 2, 16'h5555, 0, 1'b0);
    check("post_rst_count", r_count, 2);

    // Random small rectangles, some empty, random waitrequest
    for (int i = 0; i < 25; i++) begin
      int x0, x1, y0, y1;
      x0 = int'($urandom_range(1, 1015));
      x1 = x0 + int'($urandom_range(0, 5)) - 1;
      y0 = int'($urandom_range(1, 505));
      y1 = y0 + int'($urandom_range(0, 4)) - 1;
      run_cmd(x0, x1, y0, y1, 16'($urandom), 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
